mic1_exec_ctrl: RTL
===================

MIC1_EXEC_CTRL -- requirements
Module: mic1_exec_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized-high cycles required before a button press is accepted.
REQ-002 Parameter CNT_W, default 16: width of cycle_count.
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port button, input, 4: raw push-buttons.
- [0] RUN
- [1] CPU_RESET
- [2] STEP
- [3] STOP
REQ-006 Port halt_in, input, 1: datapath HALT microinstruction indication, sampled each cycle.
REQ-007 Port mpc, input, 9: current MIC-1 microprogram counter.
REQ-008 Port cpu_en, output, 1: datapath clock-enable; the datapath advances one microinstruction per cycle while high.
REQ-009 Port cpu_rst, output, 1: one-cycle synchronous reset pulse to the datapath.
REQ-010 Port led_run_status, output, 1: high in RUN.
REQ-011 Port led_idle, output, 1: high in IDLE.
REQ-012 Port led_halted, output, 1: high in HALTED.
REQ-013 Port led_run_step, output, 4: single-step counter.
REQ-014 Port cycle_count, output, CNT_W: count of cpu_en-high cycles.

Function
REQ-015 Each button bit SHALL pass through a 2-flop synchronizer and then a per-bit stability counter.
REQ-016 A press pulse SHALL be asserted for exactly one cycle when a synchronized bit has been high for DEBOUNCE_CYCLES consecutive cycles. The bit SHALL NOT produce another pulse until it has been synchronized-low for DEBOUNCE_CYCLES cycles.
REQ-017 Simultaneous press pulses SHALL be resolved by priority: CPU_RESET > STOP > STEP > RUN. Lower-priority pulses in the same cycle SHALL be discarded.
REQ-018 The FSM states SHALL be IDLE, RUN, STEP and HALTED. State updates SHALL occur on the edge after the press pulse.
REQ-019 IDLE behaviour:
- RUN pulse -> RUN.
- STEP pulse -> STEP.
- STOP pulse -> no effect.
REQ-020 RUN behaviour:
- cpu_en=1 every cycle.
- STOP pulse -> IDLE.
- halt_in=1 -> HALTED.
- If halt_in and STOP occur in the same cycle, HALTED wins.
REQ-021 STEP SHALL last exactly one cycle with cpu_en=1. It SHALL then return to IDLE, or to HALTED if halt_in=1 in that cycle.
REQ-022 led_run_step SHALL increment by 1 on each STEP exit and wrap 15->0. It SHALL clear on entry to RUN.
REQ-023 HALTED behaviour:
- cpu_en=0.
- RUN, STEP and STOP pulses SHALL be ignored.
- Only CPU_RESET leaves HALTED.
REQ-024 A CPU_RESET pulse in any state SHALL have the following effects on the next edge:
- cpu_rst=1 for one cycle.
- state -> IDLE.
- cycle_count cleared to 0.
- led_run_step cleared to 0.
- cpu_en=0 in that cycle.
REQ-025 cycle_count SHALL increment on every cycle with cpu_en=1 and saturate at 2^CNT_W-1.
REQ-026 The LED outputs SHALL be decoded from registered state and be mutually exclusive. In STEP, all three LEDs SHALL be 0.
REQ-027 cpu_en SHALL be a registered output with the value defined above for the current state.

Reset
REQ-028 While reset=1, the following SHALL hold independent of clk:
- state=IDLE
- cpu_en=0, cpu_rst=0
- led_idle=1, led_run_status=0, led_halted=0
- led_run_step=0, cycle_count=0
- synchronizers and debounce counters cleared
REQ-029 A button held high across reset deassertion SHALL be treated as a new press only after DEBOUNCE_CYCLES stable cycles.
REQ-030 Reset asserted mid-RUN SHALL force cpu_en=0 asynchronously.

Configuration
REQ-031 With macro MIC1_BREAKPOINT_EN defined:
- Input bp_addr [8:0] and input bp_valid [0:0] SHALL exist.
- In RUN, mpc==bp_addr with bp_valid=1 SHALL transition the FSM to IDLE, with cpu_en=0 from the next cycle.
- This breakpoint transition SHALL have the same priority as STOP.
REQ-032 Without MIC1_BREAKPOINT_EN, bp_addr and bp_valid SHALL NOT exist and RUN exits only per REQ-020.

Verification
REQ-033 Reset released, RUN held 20 cycles -> within 2+DEBOUNCE_CYCLES+2 cycles: led_run_status=1, cpu_en=1, cycle_count incrementing by 1 per cycle.
REQ-034 In RUN, STOP held 20 cycles -> IDLE, cpu_en=0, cycle_count frozen. Then three STEP presses separated by 40 cycles -> exactly 3 single-cycle cpu_en pulses, led_run_step=3, cycle_count +3.
REQ-035 In RUN, halt_in=1 for one cycle -> HALTED, led_halted=1. Subsequent RUN, STEP and STOP presses -> no change. CPU_RESET press -> one-cycle cpu_rst, IDLE, cycle_count=0, led_run_step=0.
REQ-036 Button bouncing 1/0 every 2 cycles for 20 cycles, then stable 1 -> exactly one press pulse. RUN and STOP pressed in the same cycle from IDLE -> FSM remains IDLE.
REQ-037 Sixteen STEP presses -> led_run_step wraps to 0. With CNT_W=4, a 20-cycle RUN -> cycle_count saturates at 15.
REQ-038 With MIC1_BREAKPOINT_EN, bp_addr=9'h010, bp_valid=1, mpc ramped from 0 in RUN -> IDLE on the cycle after mpc==9'h010, and no further cpu_en.

Source files
------------

// File: rtl/mic1_exec_ctrl.sv
// mic1_exec_ctrl: debounced front-panel run/step/stop/reset controller for the MIC-1 datapath.
// Optional breakpoint unit (bp_addr/bp_valid ports) is compiled in with `define MIC1_BREAKPOINT_EN.
module mic1_exec_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       button,
  input  logic             halt_in,
  input  logic [8:0]       mpc,
`ifdef MIC1_BREAKPOINT_EN
  input  logic [8:0]       bp_addr,
  input  logic [0:0]       bp_valid,
`endif
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic             led_run_status,
  output logic             led_idle,
  output logic             led_halted,
  output logic [3:0]       led_run_step,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_db
      logic          sync_a_reg;
      logic          sync_b_reg;
      logic          latched_reg;
      logic          press_reg;
      logic [DW-1:0] cnt_reg;

      // latched_reg remembers an accepted press; it re-arms only after a stable low run.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_a_reg  <= 1'b0;
          sync_b_reg  <= 1'b0;
          latched_reg <= 1'b0;
          press_reg   <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync_a_reg <= button[gi];
          sync_b_reg <= sync_a_reg;
          press_reg  <= 1'b0;
          if (sync_b_reg == latched_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == LAST) begin
            cnt_reg     <= '0;
            latched_reg <= sync_b_reg;
            press_reg   <= sync_b_reg;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  // Priority: CPU_RESET > STOP > STEP > RUN; losers in the same cycle are dropped.
  logic cmd_reset, cmd_stop, cmd_step, cmd_run;
  assign cmd_reset = press[1];
  assign cmd_stop  = press[3] & ~press[1];
  assign cmd_step  = press[2] & ~press[3] & ~press[1];
  assign cmd_run   = press[0] & ~press[2] & ~press[3] & ~press[1];

  logic bp_hit;
`ifdef MIC1_BREAKPOINT_EN
  assign bp_hit = bp_valid[0] && (mpc == bp_addr);
`else
  logic unused_mpc;
  assign unused_mpc = ^mpc;
  assign bp_hit     = 1'b0;
`endif

  logic [1:0] state_reg, state_next;
  logic [3:0] step_next;

  always_comb begin
    state_next = state_reg;
    step_next  = led_run_step;
    if (cmd_reset) begin
      state_next = S_IDLE;
      step_next  = 4'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_step) begin
            state_next = S_STEP;
          end else if (cmd_run) begin
            state_next = S_RUN;
            step_next  = 4'd0;
          end
        end
        S_RUN: begin
          // A halt in the same cycle as STOP/breakpoint must still land in HALTED.
          if (halt_in) state_next = S_HALTED;
          else if (cmd_stop || bp_hit) state_next = S_IDLE;
        end
        S_STEP: begin
          step_next  = led_run_step + 4'd1;
          state_next = halt_in ? S_HALTED : S_IDLE;
        end
        default: state_next = S_HALTED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cpu_en       <= 1'b0;
      cpu_rst      <= 1'b0;
      led_run_step <= 4'd0;
      cycle_count  <= '0;
    end else begin
      state_reg    <= state_next;
      cpu_en       <= (state_next == S_RUN) || (state_next == S_STEP);
      cpu_rst      <= cmd_reset;
      led_run_step <= step_next;
      if (cmd_reset) cycle_count <= '0;
      else if (cpu_en && cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign led_idle       = (state_reg == S_IDLE);
  assign led_run_status = (state_reg == S_RUN);
  assign led_halted     = (state_reg == S_HALTED);

endmodule
